// File: rtl/rn_ctrl.sv
// rn_ctrl: rename/dispatch resource controller for the 2-wide rename stage.
// Tracks free physical registers, ROB occupancy and RS occupancy, grants
// in-order rename slots from registered credit, and holds a fixed-length
// recovery window after a branch rollback.
module rn_ctrl #(
    parameter int PREG_NUM       = 64,
    parameter int AREG_NUM       = 32,
    parameter int ROB_SIZE       = 32,
    parameter int RS_SIZE        = 16,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    input  logic [1:0]                    req_has_dest,
    input  logic [1:0]                    retire_valid,
    input  logic [1:0]                    retire_free,
    input  logic [1:0]                    rs_release,
    input  logic                          rollback_en,
    output logic [1:0]                    grant,
    output logic                          rn_stall,
    output logic                          recovering,
    output logic [$clog2(PREG_NUM+1)-1:0] fl_count,
    output logic [$clog2(ROB_SIZE+1)-1:0] rob_count,
    output logic [$clog2(RS_SIZE+1)-1:0]  rs_count,
    output logic                          err
);

    localparam int FL_CAP = PREG_NUM - AREG_NUM;
    localparam int FLW    = $clog2(PREG_NUM + 1);
    localparam int ROBW   = $clog2(ROB_SIZE + 1);
    localparam int RSW    = $clog2(RS_SIZE + 1);
    localparam int RCW    = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t          state;
    logic [RCW-1:0]  rcv_cnt;

    logic [ROBW-1:0] rob_free;
    logic [RSW-1:0]  rs_free;
    logic            slot0_ok;
    logic            slot1_ok;

    int              fl_sum, rob_sum, rs_sum;
    logic [FLW-1:0]  fl_nxt;
    logic [ROBW-1:0] rob_nxt;
    logic [RSW-1:0]  rs_nxt;
    logic            cnt_bad;

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    function automatic int clamp(input int v, input int cap);
        if (v > cap) return cap;
        if (v < 0)   return 0;
        return v;
    endfunction

    // Slot grants from registered credit only; slot 1 never bypasses slot 0.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant    = 2'b00;
        rob_free = ROBW'(ROB_SIZE) - rob_count;
        rs_free  = RSW'(RS_SIZE) - rs_count;
        slot0_ok = !reset && (state == RUN) && !rollback_en && req_valid[0]
                   && (rob_free >= ROBW'(1)) && (rs_free >= RSW'(1))
                   && (!req_has_dest[0] || (fl_count >= FLW'(1)));
        slot1_ok = slot0_ok && req_valid[1]
                   && (rob_free >= ROBW'(2)) && (rs_free >= RSW'(2))
                   && (fl_count >= FLW'(pop2(req_has_dest)));
        grant    = {slot1_ok, slot0_ok};
    end

    // Stall upstream whenever a valid slot is held back or recovery is active.
    always_comb begin
        rn_stall = 1'b0;
        if (!reset)
            rn_stall = ((req_valid & ~grant) != 2'b00) || (state == RECOVER) || rollback_en;
    end

    assign recovering = (state == RECOVER);

    // Net next-cycle counter values with saturation and overflow detection.
    always_comb begin
        fl_sum  = int'(fl_count) + int'(pop2(retire_free)) - int'(pop2(grant & req_has_dest));
        rob_sum = int'(rob_count) + int'(pop2(grant)) - int'(pop2(retire_valid));
        rs_sum  = int'(rs_count) + int'(pop2(grant)) - int'(pop2(rs_release));
        fl_nxt  = FLW'(clamp(fl_sum, FL_CAP));
        rob_nxt = ROBW'(clamp(rob_sum, ROB_SIZE));
        rs_nxt  = RSW'(clamp(rs_sum, RS_SIZE));
        cnt_bad = (fl_sum  < 0) || (fl_sum  > FL_CAP)
               || (rob_sum < 0) || (rob_sum > ROB_SIZE)
               || (rs_sum  < 0) || (rs_sum  > RS_SIZE);
    end

    // RUN/RECOVER sequencing and credit counter state.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state     <= RUN;
            rcv_cnt   <= '0;
            fl_count  <= FLW'(FL_CAP);
            rob_count <= '0;
            rs_count  <= '0;
            err       <= 1'b0;
        end else if (rollback_en) begin
            // Flush all speculative occupancy regardless of same-cycle retire/release.
            state     <= RECOVER;
            rcv_cnt   <= RCW'(RECOVER_CYCLES);
            fl_count  <= FLW'(FL_CAP);
            rob_count <= '0;
            rs_count  <= '0;
        end else begin
            case (state)
                RUN: begin
                    fl_count  <= fl_nxt;
                    rob_count <= rob_nxt;
                    rs_count  <= rs_nxt;
                    err       <= err | cnt_bad;
                end
                RECOVER: begin
                    if (rcv_cnt <= RCW'(1))
                        state <= RUN;
                    rcv_cnt <= rcv_cnt - RCW'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rn_ctrl.sv
// Bench for rn_ctrl: directed per-cycle vectors push expected outputs into a
// queue; a monitor pops one entry per cycle at the falling edge and compares.
module tb_rn_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = '0, req_has_dest = '0, retire_valid = '0;
    logic [1:0] retire_free = '0, rs_release = '0;
    logic       rollback_en = 1'b0;
    logic [1:0] grant;
    logic       rn_stall, recovering, err;
    logic [6:0] fl_count;
    logic [5:0] rob_count;
    logic [4:0] rs_count;

    typedef struct {
        logic [1:0] grant;
        logic       stall;
        logic       rec;
        int         fl;
        int         rob;
        int         rs;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    rn_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_has_dest(req_has_dest),
        .retire_valid(retire_valid), .retire_free(retire_free),
        .rs_release(rs_release), .rollback_en(rollback_en),
        .grant(grant), .rn_stall(rn_stall), .recovering(recovering),
        .fl_count(fl_count), .rob_count(rob_count), .rs_count(rs_count),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, want);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant",      int'(grant),      int'(e.grant));
                check("rn_stall",   int'(rn_stall),   int'(e.stall));
                check("recovering", int'(recovering), int'(e.rec));
                check("fl_count",   int'(fl_count),   e.fl);
                check("rob_count",  int'(rob_count),  e.rob);
                check("rs_count",   int'(rs_count),   e.rs);
                check("err",        int'(err),        int'(e.err));
            end
        end
    end

    // Drive one cycle of inputs, queue the expected outputs, advance one cycle.
    task automatic cyc(input logic rst_v, input logic [1:0] rv, input logic [1:0] hd,
                       input logic [1:0] rtv, input logic [1:0] rtf, input logic [1:0] rsr,
                       input logic rb, input logic [1:0] eg, input logic es, input logic er,
                       input int efl, input int erob, input int ers, input logic eerr);
        exp_t e;
        reset        = rst_v;
        req_valid    = rv;
        req_has_dest = hd;
        retire_valid = rtv;
        retire_free  = rtf;
        rs_release   = rsr;
        rollback_en  = rb;
        e.grant = eg; e.stall = es; e.rec = er;
        e.fl = efl; e.rob = erob; e.rs = ers; e.err = eerr;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        // Reset held with requests present: no grant, no stall, reset counters.
        cyc(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 32, 0, 0, 0);
        // Both slots with dest right after reset.
        cyc(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b11, 0, 0, 32, 0, 0, 0);
        // Drain free list two at a time while ROB/RS stay balanced at 2.
        for (int j = 1; j <= 14; j++)
            cyc(0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 0, 2'b11, 0, 0, 32 - 2 * j, 2, 2, 0);
        cyc(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 0, 2'b01, 0, 0, 2, 2, 2, 0);
        // fl_count=1 with two dest requests: only slot 0.
        cyc(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b01, 1, 0, 1, 2, 2, 0);
        // fl_count=0; same-cycle free is not usable yet.
        cyc(0, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 0, 2'b00, 1, 0, 0, 3, 3, 0);
        cyc(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b01, 1, 0, 1, 2, 3, 0);
        // Rollback at R with requests held; retire inputs during RECOVER ignored.
        cyc(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0, 0, 3, 4, 0);
        cyc(0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 0, 2'b00, 1, 1, 32, 0, 0, 0);
        cyc(0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 0, 2'b00, 1, 1, 32, 0, 0, 0);
        cyc(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b11, 0, 0, 32, 0, 0, 0);
        // Simultaneous allocate, retire and release net out.
        cyc(0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 0, 2'b11, 0, 0, 30, 2, 2, 0);
        cyc(0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0, 0, 30, 2, 3, 0);
        // Fill the ROB without dests, RS kept flat by releases.
        for (int k = 0; k <= 14; k++)
            cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 0, 2'b11, 0, 0, 30, 1 + 2 * k, 3, 0);
        cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 0, 2'b01, 1, 0, 30, 31, 3, 0);
        cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 30, 32, 2, 0);
        cyc(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0, 0, 30, 32, 2, 0);
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 30, 30, 2, 0);
        // Rollback to restore a full free list, then overflow it.
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0, 30, 30, 2, 0);
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 1, 32, 0, 0, 0);
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 1, 32, 0, 0, 0);
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'b00, 0, 0, 32, 0, 0, 0);
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 32, 0, 0, 1);
        // err survives rollback; reset asserted mid-RECOVER clears everything.
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0, 32, 0, 0, 1);
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 1, 32, 0, 0, 1);
        cyc(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 32, 0, 0, 0);
        cyc(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b11, 0, 0, 32, 0, 0, 0);
        // A lone slot-1 request is never granted.
        cyc(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 30, 2, 2, 0);
        cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 30, 2, 2, 0);

        // Bounded wait for the monitor to consume every queued expectation.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(posedge clock);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
